// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a power-of-two byte FIFO feeding an 8-bit serial framer
// with optional even parity and one or two stop bits. Format and bit period are latched per frame.
module uart_tx_buffered #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_50mhz,
  input  logic        rst_n,
  input  logic [15:0] tx_divider,
  input  logic        parity_en,
  input  logic        two_stop,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic        tx_line,
  output logic        tx_busy,
  output logic [4:0]  fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, load, bit_done, tx_next;
  logic [15:0]   div_q, baud_cnt;
  logic          par_en_q, two_stop_q, par_q;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;

  assign wr_ready = (fifo_count < 5'(FIFO_DEPTH));
  assign push     = wr_valid & wr_ready;
  assign tx_busy  = (state != IDLE);
  assign bit_done = (baud_cnt == div_q);

  // NOTE: the storage array has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk_50mhz) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   fifo_count <= fifo_count + 5'd1;
        2'b01:   fifo_count <= fifo_count - 5'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (fifo_count != 5'd0) begin
          load    = 1'b1;
          state_n = START;
        end
      end
      START:  if (bit_done) state_n = DATA;
      DATA:   if (bit_done && bit_idx == 3'd7) state_n = par_en_q ? PARITY : STOP1;
      PARITY: if (bit_done) state_n = STOP1;
      STOP1, STOP2: begin
        if (bit_done) begin
          if (state == STOP1 && two_stop_q) begin
            state_n = STOP2;
          end else if (fifo_count != 5'd0) begin
            load    = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line level for the upcoming state; the shift register moves on the same edge as a DATA bit ends.
  always_comb begin
    tx_next = 1'b1;
    case (state_n)
      START:   tx_next = 1'b0;
      DATA:    tx_next = (state == DATA && bit_done) ? shreg[1] : shreg[0];
      PARITY:  tx_next = par_q;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_line <= 1'b1;
    end else begin
      state   <= state_n;
      tx_line <= tx_next;
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt   <= 16'd0;
      bit_idx    <= 3'd0;
      shreg      <= 8'd0;
      div_q      <= 16'd0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      par_q      <= 1'b0;
    end else if (load) begin
      div_q      <= tx_divider;
      par_en_q   <= parity_en;
      two_stop_q <= two_stop;
      shreg      <= mem[rd_ptr];
      par_q      <= ^mem[rd_ptr];
      baud_cnt   <= 16'd0;
      bit_idx    <= 3'd0;
    end else if (state != IDLE) begin
      if (bit_done) begin
        baud_cnt <= 16'd0;
        if (state == DATA) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 1'b1;
        end
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
    end
  end

endmodule
